dot_reduce: RTL and testbench



---
 rtl/dot_reduce.sv | 125 ++++++++++++
 tb/tb_dot_reduce.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_reduce.sv
// Streaming dot-product reducer: NUM_LANES multiplies per beat, a registered lane-sum
// tree, then accumulation over NUM_ELEMENTS beats into one result.
module dot_reduce #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_LANES    = 4,
  parameter int NUM_ELEMENTS = 5,
  parameter int PIPE_WIDTH   = 2,
  parameter int SIGNED       = 1,
  localparam int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(NUM_LANES) + $clog2(NUM_ELEMENTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dot_reduce_clear_in,
  output logic                            dot_reduce_ready_in,
  input  logic                            dot_reduce_valid_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] dot_reduce_dataa_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] dot_reduce_datab_in,
  input  logic                            dot_reduce_ready_out,
  output logic                            dot_reduce_valid_out,
  output logic [RESULT_WIDTH-1:0]         dot_reduce_result_out
);

  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  localparam int CNT_WIDTH  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  logic                    en;
  logic                    in_hs;
  logic [PROD_WIDTH-1:0]   prod_w        [NUM_LANES];
  logic [RESULT_WIDTH-1:0] prod_ext      [NUM_LANES];
  logic [PROD_WIDTH-1:0]   mult_pipe_reg [PIPE_WIDTH][NUM_LANES];
  logic [PIPE_WIDTH-1:0]   mult_valid_reg;
  logic [RESULT_WIDTH-1:0] tree_sum_next;
  logic [RESULT_WIDTH-1:0] tree_sum_reg;
  logic                    tree_valid_reg;
  logic [RESULT_WIDTH-1:0] acc_reg;
  logic [RESULT_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0]    beat_cnt_reg;
  logic                    final_beat;
  logic                    valid_out_reg;
  logic [RESULT_WIDTH-1:0] result_reg;

  assign en                    = !valid_out_reg || dot_reduce_ready_out;
  assign dot_reduce_ready_in   = en;
  assign in_hs                 = dot_reduce_valid_in && en && !dot_reduce_clear_in;
  assign dot_reduce_valid_out  = valid_out_reg;
  assign dot_reduce_result_out = result_reg;

  // Operands are widened to the product width first so a plain multiply is exact.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [PROD_WIDTH-1:0] a_ext;
      logic [PROD_WIDTH-1:0] b_ext;
      if (SIGNED != 0) begin : g_sext
        assign a_ext        = PROD_WIDTH'($signed(dot_reduce_dataa_in[gi*DATA_WIDTH +: DATA_WIDTH]));
        assign b_ext        = PROD_WIDTH'($signed(dot_reduce_datab_in[gi*DATA_WIDTH +: DATA_WIDTH]));
        assign prod_ext[gi] = RESULT_WIDTH'($signed(mult_pipe_reg[PIPE_WIDTH-1][gi]));
      end else begin : g_zext
        assign a_ext        = PROD_WIDTH'(dot_reduce_dataa_in[gi*DATA_WIDTH +: DATA_WIDTH]);
        assign b_ext        = PROD_WIDTH'(dot_reduce_datab_in[gi*DATA_WIDTH +: DATA_WIDTH]);
        assign prod_ext[gi] = RESULT_WIDTH'(mult_pipe_reg[PIPE_WIDTH-1][gi]);
      end
      assign prod_w[gi] = a_ext * b_ext;
    end
  endgenerate

  always_comb begin
    tree_sum_next = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      tree_sum_next = tree_sum_next + prod_ext[k];
    end
  end

  // Data path carries no reset; the valid tags alone decide what is consumed.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        mult_pipe_reg[0][k] <= prod_w[k];
        for (int s = 1; s < PIPE_WIDTH; s++) begin
          mult_pipe_reg[s][k] <= mult_pipe_reg[s-1][k];
        end
      end
      tree_sum_reg <= tree_sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || dot_reduce_clear_in) begin
      mult_valid_reg <= '0;
      tree_valid_reg <= 1'b0;
    end else if (en) begin
      mult_valid_reg <= PIPE_WIDTH'({mult_valid_reg, in_hs});
      tree_valid_reg <= mult_valid_reg[PIPE_WIDTH-1];
    end
  end

  assign final_beat = tree_valid_reg && (beat_cnt_reg == CNT_WIDTH'(NUM_ELEMENTS-1));
  assign acc_sum    = acc_reg + tree_sum_reg;

  // Clear aborts the partial sum but leaves an already-held result for the consumer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg       <= '0;
      beat_cnt_reg  <= '0;
      valid_out_reg <= 1'b0;
      result_reg    <= '0;
    end else if (dot_reduce_clear_in) begin
      acc_reg      <= '0;
      beat_cnt_reg <= '0;
      if (en) begin
        valid_out_reg <= 1'b0;
      end
    end else if (en) begin
      valid_out_reg <= final_beat;
      if (final_beat) begin
        result_reg   <= acc_sum;
        acc_reg      <= '0;
        beat_cnt_reg <= '0;
      end else if (tree_valid_reg) begin
        acc_reg      <= acc_sum;
        beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dot_reduce.sv
// Bench for dot_reduce: a signed and an unsigned instance share every input and are
// checked against a result scoreboard fed by vector tables or a reference model.
module tb_dot_reduce;
  localparam int DW = 12;
  localparam int L  = 4;
  localparam int N  = 5;
  localparam int PW = 2;
  localparam int RW = 2*DW + $clog2(L) + $clog2(N);

  logic clk = 1'b0, rst = 1'b0, clear_in = 1'b0, valid_in = 1'b0, ready_out = 1'b1;
  logic [L*DW-1:0] dataa = '0, datab = '0;
  logic ready_in_s, valid_out_s, ready_in_u, valid_out_u;
  logic [RW-1:0] result_s, result_u;

  always #5 clk = ~clk;

  dot_reduce #(.DATA_WIDTH(DW), .NUM_LANES(L), .NUM_ELEMENTS(N), .PIPE_WIDTH(PW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .dot_reduce_clear_in(clear_in), .dot_reduce_ready_in(ready_in_s),
    .dot_reduce_valid_in(valid_in), .dot_reduce_dataa_in(dataa), .dot_reduce_datab_in(datab),
    .dot_reduce_ready_out(ready_out), .dot_reduce_valid_out(valid_out_s), .dot_reduce_result_out(result_s));

  dot_reduce #(.DATA_WIDTH(DW), .NUM_LANES(L), .NUM_ELEMENTS(N), .PIPE_WIDTH(PW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .dot_reduce_clear_in(clear_in), .dot_reduce_ready_in(ready_in_u),
    .dot_reduce_valid_in(valid_in), .dot_reduce_dataa_in(dataa), .dot_reduce_datab_in(datab),
    .dot_reduce_ready_out(ready_out), .dot_reduce_valid_out(valid_out_u), .dot_reduce_result_out(result_u));

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    longint        exp_s;
    longint        exp_u;
  } vec_t;

  int checks = 0, errors = 0;
  int n_results = 0, n_pushed = 0;
  logic [RW-1:0] q_s[$], q_u[$];
  bit use_model = 1'b0;
  bit rand_on = 1'b0;
  longint m_acc_s = 0, m_acc_u = 0;
  int m_cnt = 0;

  function automatic longint lane_sum(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b, input bit sgn);
    longint s = 0;
    logic [DW-1:0] x, y;
    for (int k = 0; k < L; k++) begin
      x = a[k*DW +: DW];
      y = b[k*DW +: DW];
      if (sgn) s += longint'($signed(x)) * longint'($signed(y));
      else     s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  function automatic logic [L*DW-1:0] rep(input logic [DW-1:0] v);
    return {L{v}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input longint es, input longint eu);
    q_s.push_back(RW'(es));
    q_u.push_back(RW'(eu));
    n_pushed++;
  endtask

  // Scoreboard / model process; inputs are driven at posedge+1 so negedge sees settled values.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!rst) begin
      m_acc_s = 0; m_acc_u = 0; m_cnt = 0;
      q_s.delete(); q_u.delete();
    end else begin
      if (valid_out_s && ready_out) begin
        n_results++;
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_s_unexpected: got %0d expected none", result_s);
        end else begin
          e = q_s.pop_front();
          $display("txn %0d: signed result %0d expected %0d", n_results, $signed(result_s), $signed(e));
          check("result_s", 64'(result_s), 64'(e));
        end
      end
      if (valid_out_u && ready_out) begin
        if (q_u.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_u_unexpected: got %0d expected none", result_u);
        end else begin
          e = q_u.pop_front();
          check("result_u", 64'(result_u), 64'(e));
        end
      end
      if (clear_in) begin
        m_acc_s = 0; m_acc_u = 0; m_cnt = 0;
      end else if (valid_in && ready_in_s) begin
        m_acc_s += lane_sum(dataa, datab, 1'b1);
        m_acc_u += lane_sum(dataa, datab, 1'b0);
        m_cnt++;
        if (m_cnt == N) begin
          if (use_model) push_exp(m_acc_s, m_acc_u);
          m_acc_s = 0; m_acc_u = 0; m_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
    int t = 0;
    dataa = a; datab = b; valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in_s && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_in stayed %0d, required 1", ready_in_s);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit push,
                            input longint es, input longint eu);
    for (int i = 0; i < N; i++) send(rep(a), rep(b));
    if (push) push_exp(es, eu);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 64'(q_s.size() + q_u.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int n;
    bit stable;
    int gaps;
    logic [RW-1:0] held;
    logic [L*DW-1:0] ra, rb;

    tbl[0] = '{a: 12'd3,    b: 12'd2,    exp_s: 120,      exp_u: 120};
    tbl[1] = '{a: 12'hFFF,  b: 12'd7,    exp_s: -140,     exp_u: 573300};
    tbl[2] = '{a: 12'd2047, b: 12'd2047, exp_s: 83804180, exp_u: 83804180};
    tbl[3] = '{a: 12'h800,  b: 12'h800,  exp_s: 83886080, exp_u: 83886080};
    tbl[4] = '{a: 12'hFFF,  b: 12'hFFF,  exp_s: 20,       exp_u: 335380500};
    tbl[5] = '{a: 12'd1,    b: 12'd1,    exp_s: 20,       exp_u: 20};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_valid_out", 64'(valid_out_s), 64'd0);
    check("reset_result_out", 64'(result_s), 64'd0);
    check("reset_ready_in", 64'(ready_in_s), 64'd1);

    // Single frame: latency and one-cycle valid pulse
    send_frame(tbl[0].a, tbl[0].b, 1'b1, tbl[0].exp_s, tbl[0].exp_u);
    n = 0;
    while (!valid_out_s && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_cycles", 64'(n + 1), 64'(PW + 2));
    @(posedge clk); #1;
    check("valid_one_cycle", 64'(valid_out_s), 64'd0);

    // Back-to-back frames and operand extremes from the vector table
    gaps = 0;
    for (int i = 1; i <= 4; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!ready_in_s) gaps++;
        send(rep(tbl[i].a), rep(tbl[i].b));
      end
      push_exp(tbl[i].exp_s, tbl[i].exp_u);
    end
    check("no_input_gaps", 64'(gaps), 64'd0);
    drain("drain_table");

    // Backpressure: result held, pipeline frozen, then released
    ready_out = 1'b0;
    fork
      begin
        send_frame(tbl[0].a, tbl[0].b, 1'b1, tbl[0].exp_s, tbl[0].exp_u);
        send_frame(tbl[5].a, tbl[5].b, 1'b1, tbl[5].exp_s, tbl[5].exp_u);
      end
      begin
        n = 0;
        while (!valid_out_s && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        held = result_s;
        stable = 1'b1;
        repeat (10) begin
          @(posedge clk); #1;
          if (!valid_out_s || result_s !== held || ready_in_s) stable = 1'b0;
        end
        check("bp_held_stable", 64'(stable), 64'd1);
        check("bp_held_value", 64'(held), 64'd120);
        ready_out = 1'b1;
      end
    join
    drain("drain_bp");

    // Clear after 3 beats; the beat handshaken with clear is dropped
    for (int i = 0; i < 3; i++) send(rep(12'd5), rep(12'd5));
    clear_in = 1'b1;
    send(rep(12'd9), rep(12'd9));
    clear_in = 1'b0;
    send_frame(tbl[5].a, tbl[5].b, 1'b1, tbl[5].exp_s, tbl[5].exp_u);
    drain("drain_clear");

    // Reset mid-accumulation
    send(rep(12'd9), rep(12'd9));
    send(rep(12'd9), rep(12'd9));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_valid_out", 64'(valid_out_s), 64'd0);
    send_frame(tbl[5].a, tbl[5].b, 1'b1, tbl[5].exp_s, tbl[5].exp_u);
    drain("drain_rst_mid");

    // Reset with a held result discards it
    ready_out = 1'b0;
    send_frame(tbl[0].a, tbl[0].b, 1'b0, 0, 0);
    n = 0;
    while (!valid_out_s && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_before_rst", 64'(valid_out_s), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_held_valid_out", 64'(valid_out_s), 64'd0);
    check("rst_held_result_out", 64'(result_s), 64'd0);
    ready_out = 1'b1;
    send_frame(tbl[5].a, tbl[5].b, 1'b1, tbl[5].exp_s, tbl[5].exp_u);
    drain("drain_rst_held");

    // Random traffic against the reference model
    use_model = 1'b1;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int f = 0; f < 1000; f++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        for (int k = 0; k < L; k++) begin
          ra[k*DW +: DW] = DW'($urandom);
          rb[k*DW +: DW] = DW'($urandom);
        end
        send(ra, rb);
      end
    end
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 ready_out = 1'b1;
    drain("drain_random");
    check("result_count", 64'(n_results), 64'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
